led_mmio_port: RTL
==================

Name: led_mmio_port

Overview:
- Parametrised memory-mapped LED output peripheral for the pipelined CPU on the iCE40 top level.
- Decodes a small word-addressed register window on the CPU memory read/write buses.
- Drives NUM_LEDS outputs, each independently set to off, on, blink, or one-shot pulse.
- All state advances only on clk_enable ticks from clock_div, so LED timing scales with the CPU step rate.

Parameters:
- NUM_LEDS, 5, number of LED channels; legal range 1..16 (2 mode bits per channel in one 32-bit word).
- ADDR_WIDTH, 8, CPU word-address width.
- BASE_ADDR, 8'hF0, word address of register 0; window is BASE_ADDR..BASE_ADDR+3.
- PERIOD_WIDTH, 16, width of the blink/pulse half-period counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset; one clock, reset sampled on the rising edge of clk.
- clk_enable  in  1  tick from clock_div; all non-reset state updates are gated by it.
- read_address  in  ADDR_WIDTH  CPU read word address.
- write_address  in  ADDR_WIDTH  CPU write word address.
- write_data  in  32  CPU write data.
- write_enable  in  1  CPU write strobe; qualified by clk_enable.
- read_data  out  32  registered read data for read_address.
- read_hit  out  1  registered; 1 when the sampled read_address fell in the window.
- leds  out  NUM_LEDS  LED drive, active high.

Behaviour:
- Register map, offset from BASE_ADDR:
  - 0 MODE (RW): bits [2i+1:2i] for channel i; 00 off, 01 on, 10 blink, 11 pulse.
  - 1 HALF_PERIOD (RW): [PERIOD_WIDTH-1:0], counted in clk_enable ticks; a value of 0 is treated as 1.
  - 2 LED_STATE (RO): [NUM_LEDS-1:0] = current leds.
  - 3 PULSE_DONE (RW1C): bit i is sticky, set when the channel i pulse completes.
  - Unused and out-of-window bits read 0. Writes outside the window, and writes to offset 2, are ignored.
- Reset (rst_n=0 at a clk edge) clears everything, regardless of clk_enable and mid-pulse:
  - MODE=0, HALF_PERIOD=1, PULSE_DONE=0.
  - Blink counter=0, blink phase=0, pulse counters=0.
  - leds=0, read_data=0, read_hit=0.
- Read: on each clk_enable tick, read_data and read_hit capture the register selected by read_address, one clk latency. They hold between ticks.
- Write: takes effect at the clk edge where write_enable & clk_enable. A read of the same register on the same tick returns the old value.
- Blink engine (shared by all channels):
  - Counter increments each tick.
  - When counter == eff_half-1: counter←0 and phase toggles.
  - A write to HALF_PERIOD sets counter←0 and phase←0 on that tick.
- Pulse (per channel):
  - Writing MODE with channel i = 11, when it was previously ≠ 11, loads pulse_cnt_i ← eff_half. Rewriting 11 onto 11 does not restart the pulse.
  - While pulse_cnt_i ≠ 0, leds[i]=1 and the counter decrements each tick.
  - On the tick it reaches 0: MODE[i]←00 and PULSE_DONE[i]←1.
  - Changing channel i to another mode mid-pulse cancels the pulse: pulse_cnt_i←0 and done is not set.
- leds[i] is registered and updated on each tick from the post-update state:
  - off → 0; on → 1; blink → phase; pulse → (pulse_cnt_i ≠ 0).
  - Result: one tick of latency from a MODE write to the leds change.
- Simultaneous events:
  - A W1C on PULSE_DONE in the same tick as a pulse completing on that bit: the set wins, bit stays 1.
  - A MODE write in the same tick as hardware auto-clearing MODE[i]: the CPU write wins for all channels, and that channel's done bit is still set.
- clk_enable=0: all state, outputs and read_data hold.

Test Plan:
- Reset with clk_enable=1, then read offsets 0..3 → read_data 0, 1, 0, 0 and read_hit=1. Read address 8'h10 → read_hit=0, read_data=0.
- Write MODE=32'h2 (ch0 blink), HALF_PERIOD=3 → leds[0] toggles every 3 ticks, starting low; 0,0,0,1,1,1,0… after the HALF_PERIOD write.
- Write MODE ch1=11 with HALF_PERIOD=4 → leds[1]=1 for exactly 4 ticks. Then MODE[3:2]=00, PULSE_DONE=32'h2, and a W1C write of 32'h2 clears it.
- Start a ch2 pulse, then write ch2=01 two ticks later → leds[2] stays 1, PULSE_DONE[2] remains 0.
- HALF_PERIOD=0 with blink → behaves as 1: leds toggle every tick. Hold clk_enable=0 for 10 clks → leds and read_data frozen.
- Assert rst_n=0 for one clk mid-pulse and mid-blink → all outputs 0 next edge, MODE=0, with no done bit set.

Source files
------------

// File: rtl/led_mmio_port.sv
// led_mmio_port: memory-mapped LED peripheral for the CPU bus.
// Off/on/blink/pulse per channel, stepped by clk_enable ticks.
module led_mmio_port #(
  parameter int NUM_LEDS = 5,
  parameter int ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(8'hF0),
  parameter int PERIOD_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_enable,
  input  logic [ADDR_WIDTH-1:0] read_address,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [31:0]           write_data,
  input  logic                  write_enable,
  output logic [31:0]           read_data,
  output logic                  read_hit,
  output logic [NUM_LEDS-1:0]   leds
);

  localparam int MW = 2 * NUM_LEDS;
  localparam logic [PERIOD_WIDTH-1:0] ONE = PERIOD_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] WIN = ADDR_WIDTH'(4);

  logic [MW-1:0]           mode_q, mode_d;
  logic [PERIOD_WIDTH-1:0] half_q, half_d;
  logic [PERIOD_WIDTH-1:0] bcnt_q, bcnt_d;
  logic [PERIOD_WIDTH-1:0] eff_half;
  logic                    phase_q, phase_d;
  logic [NUM_LEDS-1:0]     done_q, done_d;
  logic [NUM_LEDS-1:0]     leds_q, leds_d;
  logic [PERIOD_WIDTH-1:0] pcnt_q [NUM_LEDS];
  logic [PERIOD_WIDTH-1:0] pcnt_d [NUM_LEDS];
  logic [1:0]              nm [NUM_LEDS];
  logic [NUM_LEDS-1:0]     fin;
  logic [ADDR_WIDTH-1:0]   roff, woff;
  logic                    rhit, whit;
  logic                    wr_mode, wr_half, wr_done;
  logic [31:0]             rd_d, rd_q;
  logic                    hit_q;
  logic                    unused_wd;

  assign unused_wd = ^write_data;

  // Unsigned offsets make the window test wrap-safe.
  assign roff = read_address - BASE_ADDR;
  assign woff = write_address - BASE_ADDR;
  assign rhit = roff < WIN;
  assign whit = woff < WIN;

  assign wr_mode = write_enable & whit & (woff[1:0] == 2'd0);
  assign wr_half = write_enable & whit & (woff[1:0] == 2'd1);
  assign wr_done = write_enable & whit & (woff[1:0] == 2'd3);

  assign eff_half = (half_q == '0) ? ONE : half_q;

  assign leds      = leds_q;
  assign read_data = rd_q;
  assign read_hit  = hit_q;

  // Read mux: selects the pre-update register value.
  always_comb begin
    rd_d = '0;
    if (rhit) begin
      case (roff[1:0])
        2'd0:    rd_d[MW-1:0] = mode_q;
        2'd1:    rd_d[PERIOD_WIDTH-1:0] = half_q;
        2'd2:    rd_d[NUM_LEDS-1:0] = leds_q;
        default: rd_d[NUM_LEDS-1:0] = done_q;
      endcase
    end
  end

  // Next state: blink engine, pulse engines, registers, LED drive.
  always_comb begin
    mode_d  = mode_q;
    half_d  = half_q;
    done_d  = done_q;
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    pcnt_d  = pcnt_q;
    leds_d  = '0;
    fin     = '0;
    if (wr_half) begin
      half_d  = write_data[PERIOD_WIDTH-1:0];
      bcnt_d  = '0;
      phase_d = 1'b0;
    end else if (bcnt_q == eff_half - ONE) begin
      bcnt_d  = '0;
      phase_d = ~phase_q;
    end else begin
      bcnt_d = bcnt_q + ONE;
    end
    if (wr_done) begin
      done_d = done_q & ~write_data[NUM_LEDS-1:0];
    end
    for (int i = 0; i < NUM_LEDS; i++) begin
      fin[i] = (pcnt_q[i] == ONE);
      if (pcnt_q[i] != '0) begin
        pcnt_d[i] = pcnt_q[i] - ONE;
      end
      // A CPU write beats the hardware auto-clear.
      if (wr_mode) begin
        nm[i] = write_data[2*i +: 2];
      end else if (fin[i]) begin
        nm[i] = 2'b00;
      end else begin
        nm[i] = mode_q[2*i +: 2];
      end
      // Completion sets done even if a write lands on it.
      if (fin[i]) begin
        done_d[i] = 1'b1;
      end
      if (wr_mode && nm[i] == 2'b11 &&
          mode_q[2*i +: 2] != 2'b11) begin
        pcnt_d[i] = eff_half;
      end else if (nm[i] != 2'b11) begin
        pcnt_d[i] = '0;
      end
      mode_d[2*i +: 2] = nm[i];
      case (nm[i])
        2'b00:   leds_d[i] = 1'b0;
        2'b01:   leds_d[i] = 1'b1;
        2'b10:   leds_d[i] = phase_d;
        default: leds_d[i] = (pcnt_d[i] != '0);
      endcase
    end
  end

  // State registers: sync reset, otherwise advance on ticks only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q  <= '0;
      half_q  <= ONE;
      done_q  <= '0;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
      pcnt_q  <= '{default: '0};
      leds_q  <= '0;
      rd_q    <= '0;
      hit_q   <= 1'b0;
    end else if (clk_enable) begin
      mode_q  <= mode_d;
      half_q  <= half_d;
      done_q  <= done_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      pcnt_q  <= pcnt_d;
      leds_q  <= leds_d;
      rd_q    <= rd_d;
      hit_q   <= rhit;
    end
  end

endmodule
